// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and op-select constants.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    STATE_IDLE = ST_IDLE,
    STATE_RUN  = ST_RUN,
    STATE_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic c_in,
  output logic S,
  output logic c_out
);

  // Sum and carry of three input bits
  always_comb begin
    S     = A ^ B ^ c_in;
    c_out = (A & B) | (A & c_in) | (B & c_in);
  end

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract unit: operands are shifted LSB-first through one
// full_adder cell, one bit per clock, with the carry held in a register.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               carry_q,     carry_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               carry_out_q, carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               overflow_q,  overflow_d;
`endif

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   sum_next;

  // Bit cell: current LSBs plus the registered carry
  full_adder u_full_adder (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .c_in  (carry_q),
    .S     (fa_s),
    .c_out (fa_cout)
  );

  // Sum register with the new bit entering from the MSB side
  always_comb begin
    sum_next = {fa_s, sum_q[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    overflow_d  = overflow_q;
`endif

    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction is A + ~B + 1; the +1 comes in as the initial carry
          b_d     = (sub == OP_ADD) ? b : ~b;
          carry_d = (sub == OP_SUB);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = STATE_RUN;
        end
      end

      STATE_RUN: begin
        carry_d = fa_cout;
        sum_d   = sum_next;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: publish the full word only now, never a partial sum
          result_d    = sum_next;
          carry_out_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this edge
          overflow_d  = carry_q ^ fa_cout;
`endif
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = STATE_DONE;
        end
      end

      STATE_DONE: begin
        state_d = STATE_IDLE;
      end

      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  // Registered outputs
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    result    = result_q;
    carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    overflow  = overflow_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: cycle-level arithmetic model,
// directed cases with literal results, then randomized traffic.
module tb_serial_adder_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow;
`endif

  serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: ph counts cycles since acceptance (0 = free)
  int               ph = 0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_res  = '0;
  logic             m_c    = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [WIDTH-1:0] p_res;
  logic             p_c;
  logic             p_ovf;

  always @(posedge clk) begin
    int ua, ub, sa, sb, sv;
    if (rst) begin
      ph = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_c = 1'b0; m_ovf = 1'b0;
    end else if (ph == 0) begin
      m_done = 1'b0;
      if (start) begin
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (sub) begin
          p_res = WIDTH'(ua - ub);
          p_c   = (ua >= ub);
          sv    = sa - sb;
        end else begin
          p_res = WIDTH'(ua + ub);
          p_c   = ((ua + ub) >= (1 << WIDTH));
          sv    = sa + sb;
        end
        p_ovf  = (sv > (1 << (WIDTH - 1)) - 1) || (sv < -(1 << (WIDTH - 1)));
        ph     = 1;
        m_busy = 1'b1;
      end
    end else if (ph < int'(WIDTH)) begin
      ph++;
    end else if (ph == int'(WIDTH)) begin
      m_res = p_res; m_c = p_c; m_ovf = p_ovf;
      m_done = 1'b1; m_busy = 1'b0;
      ph = WIDTH + 1;
    end else begin
      ph = 0;
      m_done = 1'b0;
    end
  end

  // Compare DUT against model every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("result", 32'(result), 32'(m_res));
      check("carry_out", 32'(carry_out), 32'(m_c));
`ifdef SERIAL_ADDER_OVF_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
`endif
      if (done) done_cnt++;
    end
  end

  // Start one op, wait for done, compare DUT and model against literals
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic is,
                        input logic [WIDTH-1:0] er, input logic ec, input logic eo);
    bit got;
    int lat;
    a = ia; b = ib; sub = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    got = 1'b0; lat = 0;
    for (int i = 0; i < int'(WIDTH) + 6; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; lat = i; break; end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(WIDTH - 1));
    check("lit_result", 32'(result), 32'(er));
    check("lit_carry", 32'(carry_out), 32'(ec));
    check("model_result", 32'(m_res), 32'(er));
    check("model_carry", 32'(m_c), 32'(ec));
    check("model_ovf", 32'(m_ovf), 32'(eo));
`ifdef SERIAL_ADDER_OVF_EN
    check("lit_overflow", 32'(overflow), 32'(eo));
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulse during RUN must be ignored
    done_cnt = 0;
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_start_done_count", 32'(done_cnt), 32'd1);
    check("busy_start_result", 32'(result), 32'h46);
    check("busy_start_carry", 32'(carry_out), 32'd0);

    // Reset in the middle of RUN: no done pulse, outputs cleared
    done_cnt = 0;
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h21, 8'h13, 1'b1, 8'h0E, 1'b1, 1'b0);

    // Randomized traffic including stray starts and rare resets
    for (int i = 0; i < 1500; i++) begin
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      sub   = 1'($urandom);
      start = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
